// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scan state enum, matrix geometry and lock key codes.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int IDX_W = 2;

    localparam logic [COLS-1:0] COL_RST = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam logic [KEY_W-1:0] KEY_1     = 4'd0;
    localparam logic [KEY_W-1:0] KEY_2     = 4'd1;
    localparam logic [KEY_W-1:0] KEY_3     = 4'd2;
    localparam logic [KEY_W-1:0] KEY_4     = 4'd4;
    localparam logic [KEY_W-1:0] KEY_5     = 4'd5;
    localparam logic [KEY_W-1:0] KEY_6     = 4'd6;
    localparam logic [KEY_W-1:0] KEY_7     = 4'd8;
    localparam logic [KEY_W-1:0] KEY_8     = 4'd9;
    localparam logic [KEY_W-1:0] KEY_9     = 4'd10;
    localparam logic [KEY_W-1:0] KEY_0     = 4'd13;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'd12;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'd14;

    // Index of the lowest-numbered low bit.
    function automatic logic [IDX_W-1:0] low_idx(input logic [3:0] v);
        low_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) low_idx = IDX_W'(i);
        end
    endfunction

    // True when exactly one bit is low.
    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101,
            4'b1011, 4'b0111: one_low = 1'b1;
            default:          one_low = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer, resets to all ones (keypad idle level).
// Ports: clk, rst_n, d (async input), q (synchronized output).
module kp_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; one key_valid per press.
// Ports: clk, rst_n, row_in, col_out, key_code, key_valid, key_held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int CW = $clog2(DEBOUNCE_CNT) + 1;

    logic [ROWS-1:0]  rows_s;
    logic [DW-1:0]    dwell;
    logic             tick;
    logic [CW-1:0]    cnt, cnt_nxt;
    state_t           state, state_nxt;
    logic [IDX_W-1:0] row_q, col_q;
    logic             single, none, same;
    logic             accept, rel, adv, cap;
    logic [COLS-1:0]  col_nxt;
    logic [KEY_W-1:0] code_nxt;
    logic             held_nxt;
    logic [IDX_W-1:0] row_sel, col_sel;

    kp_sync #(.W(ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (rows_s)
    );

    assign tick   = (dwell == DW'(SCAN_DIV - 1));
    assign single = one_low(rows_s);
    assign none   = (rows_s == '1);
    // Column is held while debouncing, so same row means same key.
    assign same   = single && (low_idx(rows_s) == row_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            dwell     <= '0;
            cnt       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            col_out   <= COL_RST;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell     <= tick ? '0 : dwell + DW'(1);
            cnt       <= cnt_nxt;
            col_out   <= col_nxt;
            key_code  <= code_nxt;
            key_valid <= accept;
            key_held  <= held_nxt;
            if (cap) begin
                row_q <= row_sel;
                col_q <= col_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        rel       = 1'b0;
        adv       = 1'b0;
        cap       = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (single) begin
                        cap = 1'b1;
                        if (DEBOUNCE_CNT == 1) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = PRESSED;
                        end else begin
                            cnt_nxt   = CW'(1);
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (same) begin
                        if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
                            accept    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = PRESSED;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = SCAN;
                        adv       = 1'b1;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
                            rel       = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = SCAN;
                            adv       = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_comb begin
        // Fresh capture is used when acceptance happens on the first tick.
        row_sel  = cap ? low_idx(rows_s) : row_q;
        col_sel  = cap ? low_idx(col_out) : col_q;
        col_nxt  = adv ? {col_out[COLS-2:0], col_out[COLS-1]} : col_out;
        code_nxt = accept ? {row_sel, col_sel} : key_code;
        held_nxt = key_held;
        if (accept)   held_nxt = 1'b1;
        else if (rel) held_nxt = 1'b0;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner driven by a reactive keypad model.
// A tick-level reference model predicts columns, hold state and key events.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] press = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int vcount = 0;

    typedef struct {
        int n;
        int code;
    } ev_t;

    ev_t        sbq[$];
    logic [3:0] m_pipe[$];
    logic [3:0] rin_s = 4'hF;
    int         m_n = 0;
    int         m_cp = 0;
    int         m_mode = 0;
    int         m_streak = 0;
    int         m_row = 0;
    int         m_col = 0;
    int         m_code = 0;
    int         m_held = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical keypad: a pressed key shorts its row to a driven-low column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_n = 0;
        m_pipe = {4'hF, 4'hF};
        m_cp = 0;
        m_mode = 0;
        m_streak = 0;
        m_row = 0;
        m_col = 0;
        m_code = 0;
        m_held = 0;
    endtask

    task automatic m_accept();
        ev_t e;
        m_code = m_row * 4 + m_col;
        e.n = m_n;
        e.code = m_code;
        sbq.push_back(e);
        m_held = 1;
        m_mode = 2;
        m_streak = 0;
    endtask

    // mode 0 = scanning, 1 = confirming a press, 2 = key down
    task automatic m_step();
        logic [3:0] rs;
        int zeros;
        int idx;
        m_n++;
        rs = m_pipe.pop_front();
        m_pipe.push_back(rin_s);
        if ((m_n % SD) != 0) return;
        zeros = 0;
        idx = 0;
        for (int r = 0; r < 4; r++)
            if (!rs[r]) begin
                zeros++;
                idx = r;
            end
        case (m_mode)
            0: begin
                if (zeros == 1) begin
                    m_row = idx;
                    m_col = m_cp;
                    m_streak = 1;
                    if (m_streak >= DB) m_accept();
                    else m_mode = 1;
                end else begin
                    m_cp = (m_cp + 1) % 4;
                end
            end
            1: begin
                if (zeros == 1 && idx == m_row) begin
                    m_streak++;
                    if (m_streak >= DB) m_accept();
                end else begin
                    m_streak = 0;
                    m_mode = 0;
                    m_cp = (m_cp + 1) % 4;
                end
            end
            default: begin
                if (zeros == 0) begin
                    m_streak++;
                    if (m_streak >= DB) begin
                        m_held = 0;
                        m_mode = 0;
                        m_streak = 0;
                        m_cp = (m_cp + 1) % 4;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        endcase
    endtask

    always @(negedge clk) rin_s = row_in;

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    // Monitor: pops the scoreboard whenever the DUT presents a key event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            chk("rst_col_out", int'(col_out), 14);
            chk("rst_key_valid", int'(key_valid), 0);
            chk("rst_key_held", int'(key_held), 0);
            chk("rst_key_code", int'(key_code), 0);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("lost_event_at_reset", -1, e.code);
            end
        end else begin
            chk("col_out", int'(col_out), 15 & ~(1 << m_cp));
            chk("key_held", int'(key_held), m_held);
            chk("key_code", int'(key_code), m_code);
            while (sbq.size() > 0 && sbq[0].n < m_n) begin
                e = sbq.pop_front();
                chk("missing_key_valid_cycle", m_n, e.n);
            end
            if (key_valid) begin
                vcount++;
                if (sbq.size() == 0) begin
                    chk("unexpected_key_valid", int'(key_code), -1);
                end else begin
                    e = sbq.pop_front();
                    chk("key_valid_cycle", m_n, e.n);
                    chk("key_valid_code", int'(key_code), e.code);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_held(input int v, input string nm);
        int k;
        k = 0;
        while (int'(key_held) != v && k < 200) begin
            cyc(1);
            k++;
        end
        if (k >= 200) chk(nm, int'(key_held), v);
    endtask

    int v0;
    int hold;
    int k1;
    int k2;

    initial begin
        m_reset();
        press = '0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        chk("col_at_clk4", int'(col_out), 4'b1101);
        cyc(4);
        chk("col_at_clk8", int'(col_out), 4'b1011);
        cyc(12);

        // clean press of row 2 / col 2
        v0 = vcount;
        press = 16'(1) << 10;
        cyc(80);
        press = '0;
        cyc(40);
        chk("s2_pulses", vcount - v0, 1);
        chk("s2_code", int'(key_code), 10);
        chk("s2_released", int'(key_held), 0);

        // bouncing row 1 / col 0
        v0 = vcount;
        for (int i = 0; i < 5; i++) begin
            press = 16'(1) << 4;
            cyc(4);
            press = '0;
            cyc(4);
        end
        cyc(20);
        chk("s3_pulses", vcount - v0, 0);
        chk("s3_held", int'(key_held), 0);

        // ghost: rows 0 and 1 on column 3
        v0 = vcount;
        press = (16'(1) << 3) | (16'(1) << 7);
        cyc(40);
        press = '0;
        cyc(8);
        chk("s4_pulses", vcount - v0, 0);

        // release bounce on key 5
        v0 = vcount;
        press = 16'(1) << 5;
        wait_held(1, "s5_press_timeout");
        for (int i = 0; i < 3; i++) begin
            press = '0;
            cyc(4);
            press = 16'(1) << 5;
            cyc(4);
        end
        chk("s5_still_held", int'(key_held), 1);
        press = '0;
        cyc(30);
        chk("s5_pulses", vcount - v0, 1);
        chk("s5_released", int'(key_held), 0);

        // reset while key 14 is held
        v0 = vcount;
        press = 16'(1) << 14;
        wait_held(1, "s6_press_timeout");
        cyc(2);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(60);
        chk("s6_pulses", vcount - v0, 2);
        chk("s6_code", int'(key_code), 14);
        press = '0;
        cyc(30);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: begin
                    press = 16'(1) << k1;
                    cyc($urandom_range(30, 90));
                end
                1: begin
                    press = 16'(1) << k1;
                    cyc($urandom_range(1, 10));
                end
                2: begin
                    for (int j = 0; j < 8; j++) begin
                        press = ($urandom_range(0, 1) == 1) ? 16'(1) << k1 : '0;
                        cyc($urandom_range(1, 12));
                    end
                end
                default: begin
                    press = 16'(1) << k1;
                    hold = $urandom_range(10, 40);
                    cyc(hold);
                    press = press | (16'(1) << k2);
                    cyc($urandom_range(10, 40));
                end
            endcase
            press = '0;
            cyc($urandom_range(20, 60));
        end

        cyc(20);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the lock's LED indicator path: drives and reads a 4x4 matrix keypad, debounces it, and emits one clean key event per physical press.
- The lock controller consumes these events for digit entry and confirm/clear, and forwards them as trigger edges to the indicator logic.
- Sits between the keypad pins and the lock FSM, in the same clock domain as the controller.

Parameters:
- SCAN_DIV, 4, clocks per column dwell period; legal range >= 4, which gives time for the synchronizer and row settling.
- DEBOUNCE_CNT, 3, consecutive matching dwell samples needed to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_in  input  4  keypad rows; pulled up externally, low means pressed.
- col_out  output  4  keypad column drive; active-low one-hot.
- key_code  output  4  code of the last accepted key, computed as row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from press acceptance until release acceptance.

Behaviour:
- Reset values (asynchronous, active-low reset):
  - col_out = 4'b1110, key_code = 0, key_valid = 0, key_held = 0.
  - Dwell counter = 0, debounce counter = 0, state = SCAN.
  - Synchronizer flops = 4'b1111.
- Input synchronization: row_in passes through a 2-FF synchronizer. Only the synchronized value (rows_s) is used.
- Sample tick: asserted when the dwell counter equals SCAN_DIV-1. The counter then wraps to 0. rows_s is evaluated only on the tick.
- Row classification on each tick:
  - "single": exactly one bit of rows_s is low.
  - "none": rows_s = 4'b1111.
  - Two or more low bits (ghosting or multi-press) count as none for press detection.
- State SCAN:
  - On tick with none, rotate col_out left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - On tick with single, capture row_idx and col_idx, set the debounce counter to 1, hold the column, and go to DEBOUNCE. If DEBOUNCE_CNT = 1, go directly to accept.
- State DEBOUNCE (column held):
  - On tick with the same single row, increment the counter.
  - When the counter reaches DEBOUNCE_CNT, accept:
    - key_code <= row_idx*4 + col_idx.
    - key_valid = 1 for exactly one clock, on the cycle after the accepting tick.
    - key_held <= 1, state <= PRESSED, counter <= 0.
  - On tick with any other pattern, clear the counter, return to SCAN, and advance the column on that tick.
- State PRESSED (column held):
  - On tick with none, increment the release counter.
  - On tick with any low bit, clear the release counter.
  - When the release counter reaches DEBOUNCE_CNT: key_held <= 0, state <= SCAN, advance the column.
  - key_code holds its value through release and until the next acceptance.
  - No further key_valid while in PRESSED; there is no auto-repeat.
- Press latency: from the first tick seeing the press to key_valid is (DEBOUNCE_CNT-1) dwell periods plus 1 clock.
- Reset mid-operation: all state returns to the reset values immediately. A key still held after reset is re-detected from SCAN and produces a new key_valid.
- A second key pressed while in PRESSED is ignored. Release is accepted only when all rows read high.
- Counter widths: sized with $clog2 of the parameter value plus 1. There is no overflow because each counter saturates at its terminal value.

Decomposition:
- Shared package keypad_pkg holds:
  - The state enum {SCAN, DEBOUNCE, PRESSED}.
  - KEY_W = 4, ROWS = 4, COLS = 4.
  - The column reset pattern 4'b1110.
  - Named key codes for the lock layer: KEY_0..KEY_9, KEY_ENTER, KEY_CLEAR.
- One sub-module: kp_sync, a parameterised-width 2-FF synchronizer with asynchronous active-low reset to all ones.

Test Plan:
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
1. Reset check: hold rst_n low with rows = 4'b1111, then release. Required: col_out = 1110, key_valid = 0, key_held = 0; col_out rotates every 4 clocks, giving 1101 at clock 4 and 1011 at clock 8.
2. Clean press and release: assert row 2 low only while col_out = 1011 (col 2), hold it 20 dwell periods, then release. Required: exactly one key_valid pulse with key_code = 10; key_held is high until 3 none-ticks after release; scanning then resumes.
3. Bounce rejection: assert row 1 low during col 0 for 1 tick, high for 1 tick, repeated 5 times. Required: no key_valid, key_held stays 0, col_out keeps rotating.
4. Ghost rejection: rows = 4'b1100 during col 3. Required: treated as none, no key_valid, column advances.
5. Release bounce: in PRESSED, toggle rows between none and low on alternate ticks for 6 ticks, then hold none. Required: key_held stays 1 until 3 consecutive none-ticks, and no second key_valid.
6. Reset mid-press: assert rst_n low while in PRESSED with the key still held, then deassert. Required: outputs return to reset values, then one new key_valid with the same key_code after 3 dwell ticks on that column.
